// File: rtl/music_duck_controller.sv
// Ducks the music path while any enabled interrupt source is active: fades the
// gain down, holds it at zero, waits for a quiet hold-off, then fades back in.
module music_duck_controller #(
  parameter int NUM_SRC      = 4,
  parameter int VOL_W        = 4,
  parameter int FADE_DIV     = 2,
  parameter int RESUME_DELAY = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               is_playing,
  input  logic [NUM_SRC-1:0] interrupt,
  input  logic [NUM_SRC-1:0] int_enable,
  output logic               music,
  output logic [VOL_W-1:0]   volume,
  output logic [NUM_SRC-1:0] muted_by,
  output logic [2:0]         state
);

  localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
  localparam int HW = (RESUME_DELAY > 1) ? $clog2(RESUME_DELAY) : 1;
  localparam logic [VOL_W-1:0] VMAX      = {VOL_W{1'b1}};
  localparam logic [PW-1:0]    PRESC_TOP = PW'(FADE_DIV - 1);
  localparam logic [HW-1:0]    HOLD_TOP  = HW'(RESUME_DELAY - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FADE_IN  = 3'd1,
    PLAYING  = 3'd2,
    FADE_OUT = 3'd3,
    MUTED    = 3'd4,
    HOLD     = 3'd5
  } state_t;

  state_t             cur_state, nxt_state;
  logic [VOL_W-1:0]   vol_n;
  logic [PW-1:0]      presc, presc_n;
  logic [HW-1:0]      hold_cnt, hold_n;
  logic [NUM_SRC-1:0] mb_n;
  logic [NUM_SRC-1:0] masked;
  logic [NUM_SRC-1:0] prio;
  logic               active;

  assign masked = interrupt & int_enable;
  assign active = |masked;
  // Isolate the lowest set bit: lowest index wins.
  assign prio   = masked & (~masked + NUM_SRC'(1));

  always_comb begin
    nxt_state = cur_state;
    vol_n     = volume;
    presc_n   = presc;
    hold_n    = hold_cnt;
    mb_n      = muted_by;
    if (!is_playing) begin
      nxt_state = IDLE;
      vol_n     = '0;
      presc_n   = '0;
      hold_n    = '0;
      mb_n      = '0;
    end else begin
      case (cur_state)
        IDLE: begin
          presc_n = '0;
          hold_n  = '0;
          vol_n   = '0;
          if (active) begin
            nxt_state = MUTED;
            mb_n      = prio;
          end else begin
            nxt_state = FADE_IN;
            mb_n      = '0;
          end
        end
        FADE_IN: begin
          if (active) begin
            // Direction change drops any pending step.
            nxt_state = FADE_OUT;
            presc_n   = '0;
            mb_n      = prio;
          end else if (volume == VMAX) begin
            nxt_state = PLAYING;
          end else if (presc == PRESC_TOP) begin
            presc_n = '0;
            vol_n   = volume + VOL_W'(1);
            if (vol_n == VMAX) nxt_state = PLAYING;
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        PLAYING: begin
          vol_n = VMAX;
          if (active) begin
            nxt_state = FADE_OUT;
            presc_n   = '0;
            mb_n      = prio;
          end
        end
        FADE_OUT: begin
          if (volume == '0) begin
            nxt_state = MUTED;
            if (active) mb_n = prio;
          end else if (presc == PRESC_TOP) begin
            presc_n = '0;
            vol_n   = volume - VOL_W'(1);
            if (vol_n == '0) begin
              nxt_state = MUTED;
              if (active) mb_n = prio;
            end
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        MUTED: begin
          vol_n = '0;
          if (active) begin
            mb_n = prio;
          end else begin
            nxt_state = HOLD;
            hold_n    = '0;
          end
        end
        HOLD: begin
          vol_n = '0;
          if (active) begin
            nxt_state = MUTED;
            hold_n    = '0;
            mb_n      = prio;
          end else if (hold_cnt == HOLD_TOP) begin
            nxt_state = FADE_IN;
            hold_n    = '0;
            presc_n   = '0;
            mb_n      = '0;
          end else begin
            hold_n = hold_cnt + HW'(1);
          end
        end
        default: begin
          nxt_state = IDLE;
          vol_n     = '0;
          presc_n   = '0;
          hold_n    = '0;
          mb_n      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cur_state <= IDLE;
      volume    <= '0;
      presc     <= '0;
      hold_cnt  <= '0;
      muted_by  <= '0;
    end else begin
      cur_state <= nxt_state;
      volume    <= vol_n;
      presc     <= presc_n;
      hold_cnt  <= hold_n;
      muted_by  <= mb_n;
    end
  end

  assign music = (volume != '0);
  assign state = cur_state;

endmodule

// File: tb/tb_music_duck_controller.sv
// Bench for music_duck_controller: vector table of {inputs, cycles, expected}
// followed by hand-written resume, random masking and asynchronous reset cases.
module tb_music_duck_controller;

  localparam int W = 12;  // {music, state[2:0], volume[3:0], muted_by[3:0]}

  logic       clock;
  logic       reset;
  logic       is_playing;
  logic [3:0] interrupt;
  logic [3:0] int_enable;
  logic       music;
  logic [3:0] volume;
  logic [3:0] muted_by;
  logic [2:0] state;

  int checks;
  int failures;
  logic [W-1:0] exp_q[$];

  typedef struct {
    string      name;
    logic       play;
    logic [3:0] intr;
    logic [3:0] en;
    int         cyc;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[21];

  music_duck_controller #(
    .NUM_SRC(4), .VOL_W(4), .FADE_DIV(2), .RESUME_DELAY(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .is_playing(is_playing),
    .interrupt(interrupt),
    .int_enable(int_enable),
    .music(music),
    .volume(volume),
    .muted_by(muted_by),
    .state(state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [W-1:0] pack(input logic [2:0] st, input logic [3:0] vol,
                                        input logic [3:0] mb);
    return {(vol != 4'd0), st, vol, mb};
  endfunction

  function automatic vec_t mk(input string n, input logic p, input logic [3:0] i,
                              input logic [3:0] e, input int c, input logic [2:0] st,
                              input logic [3:0] vol, input logic [3:0] mb);
    vec_t v;
    v.name = n; v.play = p; v.intr = i; v.en = e; v.cyc = c;
    v.exp  = pack(st, vol, mb);
    return v;
  endfunction

  // driver tasks
  task automatic drive(input logic p, input logic [3:0] i, input logic [3:0] e);
    is_playing = p;
    interrupt  = i;
    int_enable = e;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // scoreboard
  task automatic check(input string name);
    logic [W-1:0] exp;
    logic [W-1:0] act;
    act = {music, state, volume, muted_by};
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s: no expected entry, got music=%0b state=%0d volume=%0d muted_by=%b",
               name, act[11], act[10:8], act[7:4], act[3:0]);
    end else begin
      exp = exp_q.pop_front();
      if (act !== exp) begin
        failures++;
        $display("FAIL %s: got music=%0b state=%0d volume=%0d muted_by=%b, want music=%0b state=%0d volume=%0d muted_by=%b",
                 name, act[11], act[10:8], act[7:4], act[3:0],
                 exp[11], exp[10:8], exp[7:4], exp[3:0]);
      end
    end
  endtask

  task automatic step(input string name, input logic p, input logic [3:0] i,
                      input logic [3:0] e, input int n, input logic [W-1:0] exp);
    drive(p, i, e);
    exp_q.push_back(exp);
    wait_cycles(n);
    check(name);
  endtask

  initial begin
    logic [3:0] r;
    checks   = 0;
    failures = 0;
    reset    = 1'b0;
    drive(1'b1, 4'h0, 4'hF);

    vecs[0]  = mk("fadein_start",  1, 4'h0, 4'hF, 1,  3'd1, 4'd0,  4'b0000);
    vecs[1]  = mk("fadein_first",  1, 4'h0, 4'hF, 2,  3'd1, 4'd1,  4'b0000);
    vecs[2]  = mk("fadein_full",   1, 4'h0, 4'hF, 28, 3'd2, 4'd15, 4'b0000);
    vecs[3]  = mk("mask_play",     1, 4'h8, 4'h7, 3,  3'd2, 4'd15, 4'b0000);
    vecs[4]  = mk("duck_enter",    1, 4'h1, 4'hF, 1,  3'd3, 4'd15, 4'b0001);
    vecs[5]  = mk("duck_first",    1, 4'h1, 4'hF, 2,  3'd3, 4'd14, 4'b0001);
    vecs[6]  = mk("duck_done",     1, 4'h1, 4'hF, 28, 3'd4, 4'd0,  4'b0001);
    vecs[7]  = mk("prio_two",      1, 4'h6, 4'hF, 1,  3'd4, 4'd0,  4'b0010);
    vecs[8]  = mk("prio_four",     1, 4'h4, 4'hF, 1,  3'd4, 4'd0,  4'b0100);
    vecs[9]  = mk("hold_enter",    1, 4'h0, 4'hF, 1,  3'd5, 4'd0,  4'b0100);
    vecs[10] = mk("hold_mid",      1, 4'h0, 4'hF, 2,  3'd5, 4'd0,  4'b0100);
    vecs[11] = mk("hold_abort",    1, 4'h4, 4'hF, 1,  3'd4, 4'd0,  4'b0100);
    vecs[12] = mk("hold_reenter",  1, 4'h0, 4'hF, 1,  3'd5, 4'd0,  4'b0100);
    vecs[13] = mk("hold_wait",     1, 4'h0, 4'hF, 7,  3'd5, 4'd0,  4'b0100);
    vecs[14] = mk("resume",        1, 4'h0, 4'hF, 1,  3'd1, 4'd0,  4'b0000);
    vecs[15] = mk("resume_step",   1, 4'h0, 4'hF, 2,  3'd1, 4'd1,  4'b0000);
    vecs[16] = mk("refade_full",   1, 4'h0, 4'hF, 28, 3'd2, 4'd15, 4'b0000);
    vecs[17] = mk("duck_to_nine",  1, 4'h1, 4'hF, 13, 3'd3, 4'd9,  4'b0001);
    vecs[18] = mk("abort_play",    0, 4'h1, 4'hF, 1,  3'd0, 4'd0,  4'b0000);
    vecs[19] = mk("idle_to_muted", 1, 4'h1, 4'hF, 1,  3'd4, 4'd0,  4'b0001);
    vecs[20] = mk("muted_stay",    1, 4'h9, 4'hF, 2,  3'd4, 4'd0,  4'b0001);

    wait_cycles(2);
    exp_q.push_back(pack(3'd0, 4'd0, 4'b0000));
    check("reset_state");
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 21; k++)
      step(vecs[k].name, vecs[k].play, vecs[k].intr, vecs[k].en, vecs[k].cyc, vecs[k].exp);

    // Quiet period from MUTED through hold-off and a complete fade-in.
    step("quiet_hold",  1, 4'h0, 4'hF, 1,  pack(3'd5, 4'd0,  4'b0001));
    step("quiet_fadein", 1, 4'h0, 4'hF, 8, pack(3'd1, 4'd0,  4'b0000));
    step("quiet_play",  1, 4'h0, 4'hF, 30, pack(3'd2, 4'd15, 4'b0000));

    // Random interrupts that are all masked off must leave playback untouched.
    for (int k = 0; k < 6; k++) begin
      r = 4'($urandom_range(0, 15));
      step("rand_masked", 1, r, ~r, 2, pack(3'd2, 4'd15, 4'b0000));
    end
    drive(1'b1, 4'h0, 4'hF);

    // Asynchronous reset mid-PLAYING, observed before the next rising edge.
    @(negedge clock);
    #2 reset = 1'b0;
    exp_q.push_back(pack(3'd0, 4'd0, 4'b0000));
    #1 check("async_reset");
    @(negedge clock);
    reset = 1'b1;
    step("post_reset", 1, 4'h0, 4'hF, 1, pack(3'd1, 4'd0, 4'b0000));

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/music_duck_controller.md
Name: music_duck_controller

Overview:
- Parametrised successor to the single-source music-off-on-ring block.
- Mutes music while any of NUM_SRC enabled interrupt sources is active (ring, alarm, navigation prompt, ...). The lowest index has the highest priority.
- Ramps volume down and up with a programmable fade rate instead of a hard cut.
- Resumes playback only after a programmable quiet hold-off. Sits between the player control logic and the audio output gain stage.

Parameters:
- NUM_SRC, 4: number of interrupt sources (>=1).
- VOL_W, 4: volume width; full scale VMAX = 2^VOL_W-1.
- FADE_DIV, 2: clock cycles per one-LSB volume step (>=1).
- RESUME_DELAY, 8: consecutive quiet cycles required before fade-in restarts (>=1).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- is_playing  in  1  user/player requests playback.
- interrupt  in  NUM_SRC  per-source interrupt active (bit i = source i).
- int_enable  in  NUM_SRC  per-source enable mask.
- music  out  1  audio path enabled; equals (volume != 0).
- volume  out  VOL_W  current gain, registered.
- muted_by  out  NUM_SRC  one-hot, highest-priority source responsible for the mute.
- state  out  3  FSM state: IDLE=0, FADE_IN=1, PLAYING=2, FADE_OUT=3, MUTED=4, HOLD=5.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; volume=0; music=0; muted_by=0.
  - Fade prescaler and hold counter are cleared.
  - Takes effect immediately, mid-operation included.
- Definitions: active = |(interrupt & int_enable). All inputs are synchronous and sampled on the rising edge.
- Priority at every edge: is_playing=0 overrides everything. The next state is IDLE, volume is forced to 0 on that same edge, and muted_by is cleared.
- IDLE:
  - is_playing & !active -> FADE_IN.
  - is_playing & active -> MUTED.
- FADE_IN:
  - The prescaler counts 0..FADE_DIV-1; volume increments by 1 when the prescaler reaches FADE_DIV-1.
  - When volume reaches VMAX -> PLAYING.
  - active -> FADE_OUT on that edge with no volume step; this also applies when VMAX would have been reached on the same edge.
- PLAYING: volume=VMAX; active -> FADE_OUT.
- FADE_OUT:
  - Volume decrements by 1 every FADE_DIV cycles; when it reaches 0 -> MUTED.
  - The fade always completes, even if active drops mid-fade.
- MUTED:
  - volume=0; music=0.
  - !active -> HOLD, with the hold counter loaded to 0.
- HOLD:
  - The hold counter increments each quiet cycle.
  - active -> MUTED, with the counter discarded.
  - Counter==RESUME_DELAY-1 with !active -> FADE_IN.
- Prescaler: cleared on every entry to FADE_IN or FADE_OUT. A step never straddles a direction change.
- Timing:
  - Interrupt sampled at edge k from PLAYING: state=FADE_OUT after edge k. The first decrement is at edge k+FADE_DIV. volume=0 after edge k+VMAX*FADE_DIV.
  - Full fade duration: VMAX*FADE_DIV cycles.
  - Quiet period starting at edge k in MUTED: HOLD after edge k; FADE_IN after edge k+RESUME_DELAY.
- muted_by:
  - Loaded with the lowest-index set bit of (interrupt & int_enable) on entry to FADE_OUT or MUTED.
  - In MUTED it tracks the current highest-priority active source every cycle.
  - Held unchanged in FADE_OUT and HOLD.
  - Cleared on entry to FADE_IN or IDLE.
- Masked sources (int_enable[i]=0) have no effect on any output.
- volume saturates: it never wraps above VMAX or below 0.
- Unused state encodings 6 and 7 -> IDLE on the next edge.

Test Plan:
- Fade-in from reset: reset=0 for 30 ns, then release with is_playing=1 and interrupt=0. Required: volume steps 0->15, one step every 2 cycles; music=1 after the first step; state=PLAYING after 30 cycles.
- Ducking: from PLAYING, assert interrupt=4'b0001. Required:
  - state=FADE_OUT on the next edge; volume=14 two cycles later.
  - volume=0, music=0, state=MUTED, muted_by=4'b0001 after 30 cycles.
- Priority: in MUTED, set interrupt=4'b0110 -> muted_by=4'b0010. Drop bit 1 while holding bit 2 -> muted_by=4'b0100 the next cycle.
- Hold-off: release all interrupts -> HOLD.
  - Reassert interrupt[2] on the 4th quiet cycle -> MUTED, volume stays 0.
  - Release again; after 8 quiet cycles -> FADE_IN and volume=1 two cycles later.
- Masking: int_enable=4'b0111 and interrupt=4'b1000 while PLAYING -> volume stays 15, state stays PLAYING, muted_by=0.
- Abort cases:
  - is_playing=0 mid FADE_OUT (volume=9) -> state=IDLE, volume=0, muted_by=0 on the next edge.
  - reset=0 mid PLAYING -> volume=0 and music=0 immediately, before the next clock edge.
